tsmp_mid_lookup_engine: RTL and testbench
=========================================

TSMP_MID_LOOKUP_ENGINE -- requirements
Module: tsmp_mid_lookup_engine

Interface
REQ-001 SHALL have parameter MID_W, 12, MID field width and RAM address width.
REQ-002 SHALL have parameter MID_LSB, 12, bit position of MID field LSB within the key.
REQ-003 SHALL have parameter KEY_W, 48, lookup key width.
REQ-004 SHALL have parameter OUT_W, 33, outport vector width; MSB is the host (CPU) port bit.
REQ-005 SHALL have parameter RAM_LAT, 2, RAM read latency in cycles (1..7).
REQ-006 SHALL have parameter FIFO_DEPTH, 4, key queue depth (power of two, >=2).
REQ-007 SHALL have parameter INIT_LOCAL, 1, when 1 the first key after reset is answered as local.
REQ-008 SHALL have parameter CNT_W, 16, statistics counter width.
REQ-009 SHALL use one clock; reset is synchronous and active-low: i_clk input 1 (125 MHz); i_rst_n input 1.
REQ-010 iv_hcp_mid input MID_W: local HCP MID.
REQ-011 i_tsmp_lookup_table_key_wr input 1: key valid strobe; iv_tsmp_lookup_table_key input KEY_W: key.
REQ-012 ov_tsmp_lookup_table_outport output OUT_W; o_tsmp_lookup_table_outport_wr output 1; o_tsmp_lookup_table_miss output 1.
REQ-013 ov_ram_raddr output MID_W; o_ram_rd output 1; iv_ram_rdata input OUT_W+1 (MSB = entry valid).
REQ-014 ov_key_drop_cnt output CNT_W; ov_lookup_miss_cnt output CNT_W; o_busy output 1 (FIFO non-empty or lookup in flight).

Function
REQ-015 Keys SHALL be pushed into the FIFO on i_..._key_wr; when FIFO full (evaluated before any same-cycle pop) the key SHALL be discarded and ov_key_drop_cnt SHALL increment, saturating at all-ones.
REQ-016 States SHALL be IDLE, RD_WAIT, RESP; one lookup in flight; answers SHALL leave in key-arrival order.
REQ-017 IDLE with FIFO non-empty SHALL pop the head; MID = key[MID_LSB+MID_W-1:MID_LSB].
REQ-018 Local case (MID == iv_hcp_mid, or first key after reset with INIT_LOCAL=1): outport SHALL be {1'b1, zeros}, miss 0, go RESP; no RAM read.
REQ-019 Remote case: o_ram_rd SHALL pulse exactly one cycle with ov_ram_raddr = MID, go RD_WAIT; elsewhere o_ram_rd=0, ov_ram_raddr=0.
REQ-020 RD_WAIT SHALL sample iv_ram_rdata exactly RAM_LAT cycles after the o_ram_rd cycle, then go RESP.
REQ-021 Sampled valid bit 1: outport = rdata[OUT_W-1:0], miss 0; valid bit 0: outport all-zero, miss 1, ov_lookup_miss_cnt +1 saturating.
REQ-022 o_..._outport_wr and miss SHALL be one-cycle pulses; outport SHALL be 0 whenever wr is 0.
REQ-023 Latency from idle/empty: local result wr 2 cycles after key strobe; remote o_ram_rd 2 cycles after key strobe, wr RAM_LAT+1 cycles after o_ram_rd.
REQ-024 RESP SHALL return to IDLE and may pop the next key in the same cycle wr is driven (back-to-back local throughput one result per 2 cycles).
REQ-025 iv_hcp_mid SHALL be compared at pop time, not at push time.

Reset
REQ-026 On i_rst_n=0 at a clock edge: all outputs 0, counters 0, FIFO empty, state IDLE, INIT_LOCAL flag re-armed; in-flight RAM data SHALL be ignored and no wr pulse issued.

Structure
REQ-027 Shared package tsmp_lookup_pkg SHALL hold the state encoding, default parameter values and the local-outport constant.
REQ-028 Key queue SHALL be sub-module tsmp_key_fifo (parametrised width/depth, full/empty, synchronous reset).

Verification
REQ-029 After reset, key MID=0x005, hcp_mid=0x001, INIT_LOCAL=1 -> wr at +2, outport 0x1_0000_0000, no o_ram_rd.
REQ-030 Remote key MID=0x0A3, RAM entry {1, 0x0_0000_0014}, RAM_LAT=2 -> raddr 0x0A3 rd one cycle, wr 3 cycles later with outport 0x0_0000_0014, miss 0.
REQ-031 Remote key to entry with valid=0 -> wr with outport 0, miss 1, ov_lookup_miss_cnt=1.
REQ-032 Six key strobes on consecutive cycles, all remote, FIFO_DEPTH=4 -> 4 or 5 answers in order as occupancy allows, ov_key_drop_cnt equals discarded count, o_busy low after last wr.
REQ-033 Reset asserted during RD_WAIT -> no wr pulse, counters 0; next key answered as local.
REQ-034 Repeat REQ-030 with RAM_LAT=4 -> wr exactly 5 cycles after o_ram_rd.

Source files
------------

// File: rtl/tsmp_lookup_pkg.sv
// Shared types and defaults for the TSMP multicast-ID lookup engine.
package tsmp_lookup_pkg;

    localparam int DEF_MID_W      = 12;
    localparam int DEF_MID_LSB    = 12;
    localparam int DEF_KEY_W      = 48;
    localparam int DEF_OUT_W      = 33;
    localparam int DEF_RAM_LAT    = 2;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_INIT_LOCAL = 1;
    localparam int DEF_CNT_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RESP    = 2'd2
    } lookup_state_t;

    // Local delivery sets only the host (CPU) bit, which is the outport MSB.
    localparam logic [DEF_OUT_W-1:0] DEF_LOCAL_OUTPORT = {1'b1, {(DEF_OUT_W-1){1'b0}}};

    function automatic logic [63:0] local_outport(input int out_w);
        local_outport = 64'd1 << (out_w - 1);
    endfunction

endpackage

// File: rtl/tsmp_key_fifo.sv
// Small synchronous FIFO holding pending lookup MIDs; pushes while full are ignored.
module tsmp_key_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == '0);
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign dout      = mem_r[rd_ptr_r];

    // Storage array: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/tsmp_mid_lookup_engine.sv
// Resolves the MID field of each queued key to an outport vector, either locally
// (host port) or through a fixed-latency RAM read; answers leave in arrival order.
module tsmp_mid_lookup_engine
    import tsmp_lookup_pkg::*;
#(
    parameter int MID_W      = DEF_MID_W,
    parameter int MID_LSB    = DEF_MID_LSB,
    parameter int KEY_W      = DEF_KEY_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int RAM_LAT    = DEF_RAM_LAT,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int INIT_LOCAL = DEF_INIT_LOCAL,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [MID_W-1:0] iv_hcp_mid,
    input  logic             i_tsmp_lookup_table_key_wr,
    input  logic [KEY_W-1:0] iv_tsmp_lookup_table_key,
    output logic [OUT_W-1:0] ov_tsmp_lookup_table_outport,
    output logic             o_tsmp_lookup_table_outport_wr,
    output logic             o_tsmp_lookup_table_miss,
    output logic [MID_W-1:0] ov_ram_raddr,
    output logic             o_ram_rd,
    input  logic [OUT_W:0]   iv_ram_rdata,
    output logic [CNT_W-1:0] ov_key_drop_cnt,
    output logic [CNT_W-1:0] ov_lookup_miss_cnt,
    output logic             o_busy
);

    localparam logic [OUT_W-1:0] LOCAL_PORT = OUT_W'(local_outport(OUT_W));
    localparam logic [2:0]       LAT_LAST   = 3'(RAM_LAT);

    lookup_state_t    state_r, state_nxt_s;
    logic [2:0]       lat_cnt_r, lat_cnt_nxt_s;
    logic             first_r, first_nxt_s;
    logic             fifo_full_s, fifo_empty_s, fifo_pop_s;
    logic [MID_W-1:0] head_mid_s;
    logic [OUT_W-1:0] outport_nxt_s, outport_r;
    logic             wr_nxt_s, wr_r;
    logic             miss_nxt_s, miss_r;
    logic             rd_nxt_s, rd_r;
    logic [MID_W-1:0] raddr_nxt_s, raddr_r;
    logic [CNT_W-1:0] drop_cnt_r, miss_cnt_r;
    logic             unused_key_s;

    // Only the MID field is queued; the rest of the key plays no part in the lookup.
    assign unused_key_s = ^iv_tsmp_lookup_table_key;

    tsmp_key_fifo #(
        .WIDTH (MID_W),
        .DEPTH (FIFO_DEPTH)
    ) u_key_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (i_tsmp_lookup_table_key_wr),
        .din   (iv_tsmp_lookup_table_key[MID_LSB +: MID_W]),
        .pop   (fifo_pop_s),
        .dout  (head_mid_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Next-state and next-output decode; the host MID is compared at pop time.
    always_comb begin
        state_nxt_s   = state_r;
        lat_cnt_nxt_s = lat_cnt_r;
        first_nxt_s   = first_r;
        fifo_pop_s    = 1'b0;
        outport_nxt_s = '0;
        wr_nxt_s      = 1'b0;
        miss_nxt_s    = 1'b0;
        rd_nxt_s      = 1'b0;
        raddr_nxt_s   = '0;
        case (state_r)
            ST_IDLE: begin
                lat_cnt_nxt_s = 3'd0;
                if (!fifo_empty_s) begin
                    fifo_pop_s  = 1'b1;
                    first_nxt_s = 1'b0;
                    if (first_r || (head_mid_s == iv_hcp_mid)) begin
                        outport_nxt_s = LOCAL_PORT;
                        wr_nxt_s      = 1'b1;
                        state_nxt_s   = ST_RESP;
                    end else begin
                        rd_nxt_s    = 1'b1;
                        raddr_nxt_s = head_mid_s;
                        state_nxt_s = ST_RD_WAIT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                // The counter is 0 in the o_ram_rd cycle, so equality marks data arrival.
                if (lat_cnt_r == LAT_LAST) begin
                    wr_nxt_s    = 1'b1;
                    state_nxt_s = ST_RESP;
                    if (iv_ram_rdata[OUT_W]) begin
                        outport_nxt_s = iv_ram_rdata[OUT_W-1:0];
                    end else begin
                        miss_nxt_s = 1'b1;
                    end
                end else begin
                    lat_cnt_nxt_s = lat_cnt_r + 3'd1;
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, registered outputs and saturating statistics.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r    <= ST_IDLE;
            lat_cnt_r  <= 3'd0;
            first_r    <= (INIT_LOCAL != 0);
            outport_r  <= '0;
            wr_r       <= 1'b0;
            miss_r     <= 1'b0;
            rd_r       <= 1'b0;
            raddr_r    <= '0;
            drop_cnt_r <= '0;
            miss_cnt_r <= '0;
        end else begin
            state_r   <= state_nxt_s;
            lat_cnt_r <= lat_cnt_nxt_s;
            first_r   <= first_nxt_s;
            outport_r <= outport_nxt_s;
            wr_r      <= wr_nxt_s;
            miss_r    <= miss_nxt_s;
            rd_r      <= rd_nxt_s;
            raddr_r   <= raddr_nxt_s;
            if (i_tsmp_lookup_table_key_wr && fifo_full_s && (drop_cnt_r != '1)) begin
                drop_cnt_r <= drop_cnt_r + CNT_W'(1);
            end
            if (miss_nxt_s && (miss_cnt_r != '1)) begin
                miss_cnt_r <= miss_cnt_r + CNT_W'(1);
            end
        end
    end

    assign ov_tsmp_lookup_table_outport   = outport_r;
    assign o_tsmp_lookup_table_outport_wr = wr_r;
    assign o_tsmp_lookup_table_miss       = miss_r;
    assign ov_ram_raddr                   = raddr_r;
    assign o_ram_rd                       = rd_r;
    assign ov_key_drop_cnt                = drop_cnt_r;
    assign ov_lookup_miss_cnt             = miss_cnt_r;
    assign o_busy                         = (state_r != ST_IDLE) || !fifo_empty_s;

endmodule

// File: tb/tb_tsmp_mid_lookup_engine.sv
// Drives two engine instances (RAM latency 2 and 4) with the same key stream and
// checks them against an answer-list reference model and a behavioural RAM.
module tb_tsmp_mid_lookup_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] hcp;
    logic        key_wr;
    logic [47:0] key;

    logic [32:0] outp  [2];
    logic        wr    [2];
    logic        miss  [2];
    logic [11:0] raddr [2];
    logic        rd    [2];
    logic [33:0] rdata [2];
    logic [15:0] dropc [2];
    logic [15:0] missc [2];
    logic        busy  [2];

    always #4 clk = ~clk;

    tsmp_mid_lookup_engine #(.RAM_LAT(2)) dut_lat2 (
        .i_clk(clk), .i_rst_n(rst_n), .iv_hcp_mid(hcp),
        .i_tsmp_lookup_table_key_wr(key_wr), .iv_tsmp_lookup_table_key(key),
        .ov_tsmp_lookup_table_outport(outp[0]), .o_tsmp_lookup_table_outport_wr(wr[0]),
        .o_tsmp_lookup_table_miss(miss[0]), .ov_ram_raddr(raddr[0]), .o_ram_rd(rd[0]),
        .iv_ram_rdata(rdata[0]), .ov_key_drop_cnt(dropc[0]), .ov_lookup_miss_cnt(missc[0]),
        .o_busy(busy[0])
    );

    tsmp_mid_lookup_engine #(.RAM_LAT(4)) dut_lat4 (
        .i_clk(clk), .i_rst_n(rst_n), .iv_hcp_mid(hcp),
        .i_tsmp_lookup_table_key_wr(key_wr), .iv_tsmp_lookup_table_key(key),
        .ov_tsmp_lookup_table_outport(outp[1]), .o_tsmp_lookup_table_outport_wr(wr[1]),
        .o_tsmp_lookup_table_miss(miss[1]), .ov_ram_raddr(raddr[1]), .o_ram_rd(rd[1]),
        .iv_ram_rdata(rdata[1]), .ov_key_drop_cnt(dropc[1]), .ov_lookup_miss_cnt(missc[1]),
        .o_busy(busy[1])
    );

    // Behavioural RAM: entry appears exactly LAT cycles after the read cycle, junk otherwise.
    logic [33:0] mem [4096];
    logic [33:0] dl0 [4];
    logic [33:0] dl1 [4];
    int          lat [2] = '{2, 4};

    always @(posedge clk) begin
        for (int s = 3; s > 0; s--) begin
            dl0[s] <= dl0[s-1];
            dl1[s] <= dl1[s-1];
        end
        dl0[0] <= rd[0] ? mem[raddr[0]] : {2'($urandom()), 32'($urandom())};
        dl1[0] <= rd[1] ? mem[raddr[1]] : {2'($urandom()), 32'($urandom())};
    end
    assign rdata[0] = dl0[1];
    assign rdata[1] = dl1[3];

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state: ordered list of expected {miss, outport} answers.
    logic [33:0] exp_q [$];
    int          rd_idx [2];
    bit          first_m;
    int          miss_m;
    int          drop_m;
    bit          mon_en = 1'b0;

    int          cyc = 0;
    int          key_cyc;
    int          rd_cyc [2];
    int          wr_cyc [2];
    int          n_rd   [2];
    logic [11:0] rd_addr [2];

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                if (wr[d] === 1'b1) begin
                    wr_cyc[d] = cyc;
                    if (rd_idx[d] < exp_q.size()) begin
                        check($sformatf("ans%0d_outport", d), 64'(outp[d]), 64'(exp_q[rd_idx[d]][32:0]));
                        check($sformatf("ans%0d_miss", d), 64'(miss[d]), 64'(exp_q[rd_idx[d]][33]));
                        rd_idx[d]++;
                    end else begin
                        check($sformatf("unexpected_wr%0d", d), 64'(1), 64'(0));
                    end
                end else begin
                    check($sformatf("quiet_out%0d", d), {30'd0, miss[d], outp[d]}, 64'(0));
                end
                if (rd[d] === 1'b1) begin
                    rd_cyc[d]  = cyc;
                    rd_addr[d] = raddr[d];
                    n_rd[d]++;
                end else begin
                    check($sformatf("quiet_raddr%0d", d), 64'(raddr[d]), 64'(0));
                end
            end
        end
    end

    task automatic send_key(input logic [11:0] mid, input logic [11:0] hcp_pop, input bit expect_ans);
        logic [32:0] e;
        logic        m;
        if (expect_ans) begin
            if (first_m || mid == hcp_pop) begin
                e = {1'b1, 32'h0};
                m = 1'b0;
            end else if (mem[mid][33]) begin
                e = mem[mid][32:0];
                m = 1'b0;
            end else begin
                e = 33'h0;
                m = 1'b1;
                miss_m++;
            end
            exp_q.push_back({m, e});
        end
        first_m = 1'b0;
        key     = {24'($urandom()), mid, 12'($urandom())};
        key_wr  = 1'b1;
        key_cyc = cyc;
        @(negedge clk);
        key_wr  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy[0] !== 1'b0 || busy[1] !== 1'b0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 64'(n >= 300), 64'(0));
        for (int d = 0; d < 2; d++) begin
            check($sformatf("pending%0d", d), 64'(exp_q.size() - rd_idx[d]), 64'(0));
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        key_wr = 1'b0;
        for (int d = 0; d < 2; d++) rd_idx[d] = exp_q.size();
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        first_m = 1'b1;
        miss_m  = 0;
        drop_m  = 0;
    endtask

    task automatic clear_rd();
        for (int d = 0; d < 2; d++) n_rd[d] = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          len;
        logic [11:0] mid;
        for (int i = 0; i < 4096; i++) mem[i] = {2'($urandom()), 32'($urandom())};
        mem[12'h005] = {1'b1, 33'h0_0000_0077};
        mem[12'h0A3] = {1'b1, 33'h0_0000_0014};
        mem[12'h0B0] = {1'b0, 33'h1_2345_6789};
        mem[12'h2AA] = {1'b1, 33'h0_DEAD_BEEF};
        rst_n  = 1'b0;
        key_wr = 1'b0;
        key    = 48'h0;
        hcp    = 12'h001;
        repeat (3) @(negedge clk);
        do_reset();
        mon_en = 1'b1;
        clear_rd();

        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_outport%0d", d), 64'(outp[d]), 64'(0));
            check($sformatf("rst_wr_miss%0d", d), {62'd0, wr[d], miss[d]}, 64'(0));
            check($sformatf("rst_ram%0d", d), {51'd0, rd[d], raddr[d]}, 64'(0));
            check($sformatf("rst_cnts%0d", d), {32'd0, dropc[d], missc[d]}, 64'(0));
            check($sformatf("rst_busy%0d", d), 64'(busy[d]), 64'(0));
        end

        // First key after reset is local even though MID differs from the host MID.
        send_key(12'h005, 12'h001, 1'b1);
        wait_idle();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("local_lat%0d", d), 64'(wr_cyc[d] - key_cyc), 64'(2));
            check($sformatf("local_no_rd%0d", d), 64'(n_rd[d]), 64'(0));
        end

        // Remote hit: read address, single rd pulse, latency per instance.
        clear_rd();
        send_key(12'h0A3, 12'h001, 1'b1);
        wait_idle();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rd_lat%0d", d), 64'(rd_cyc[d] - key_cyc), 64'(2));
            check($sformatf("rd_addr%0d", d), 64'(rd_addr[d]), 64'(12'h0A3));
            check($sformatf("rd_pulses%0d", d), 64'(n_rd[d]), 64'(1));
            check($sformatf("wr_after_rd%0d", d), 64'(wr_cyc[d] - rd_cyc[d]), 64'(lat[d] + 1));
        end

        // Remote entry with valid bit clear.
        send_key(12'h0B0, 12'h001, 1'b1);
        wait_idle();
        for (int d = 0; d < 2; d++) check($sformatf("miss_cnt%0d", d), 64'(missc[d]), 64'(1));

        // Host MID changes after the push but before the pop: the pop-time value decides.
        clear_rd();
        send_key(12'h2AA, 12'h2AA, 1'b1);
        hcp = 12'h2AA;
        wait_idle();
        hcp = 12'h001;
        for (int d = 0; d < 2; d++) check($sformatf("poptime_no_rd%0d", d), 64'(n_rd[d]), 64'(0));

        // Six back-to-back remote keys: one popped, four queued, the sixth dropped.
        for (int i = 0; i < 6; i++) send_key(12'h100 + 12'(i), 12'h001, i < 5);
        drop_m = 1;
        wait_idle();
        for (int d = 0; d < 2; d++) check($sformatf("drop_cnt%0d", d), 64'(dropc[d]), 64'(1));

        // Reset while waiting on RAM data: no answer, counters cleared, next key local.
        send_key(12'h0A3, 12'h001, 1'b0);
        repeat (2) @(negedge clk);
        do_reset();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_mid_drop%0d", d), 64'(dropc[d]), 64'(0));
            check($sformatf("rst_mid_miss%0d", d), 64'(missc[d]), 64'(0));
        end
        repeat (8) @(negedge clk);
        clear_rd();
        send_key(12'h0A3, 12'h001, 1'b1);
        wait_idle();
        for (int d = 0; d < 2; d++) check($sformatf("rearm_no_rd%0d", d), 64'(n_rd[d]), 64'(0));

        // Randomised bursts of at most five keys, never enough to overflow the queue.
        for (int b = 0; b < 40; b++) begin
            if (b % 10 == 9) do_reset();
            hcp = 12'($urandom());
            len = $urandom_range(5, 1);
            for (int i = 0; i < len; i++) begin
                mid = ($urandom_range(3, 0) == 0) ? hcp : 12'($urandom());
                send_key(mid, hcp, 1'b1);
                repeat ($urandom_range(2, 0)) @(negedge clk);
            end
            wait_idle();
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("final_miss_cnt%0d", d), 64'(missc[d]), 64'(miss_m));
            check($sformatf("final_drop_cnt%0d", d), 64'(dropc[d]), 64'(drop_m));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
